// File: rtl/fpaddsub_pkg.sv
// Shared widths and sideband type for the FP add/sub normalization stage.
package fpaddsub_pkg;

    localparam int unsigned SUM_W  = 27;          // {Cout, hidden, frac, G, R}
    localparam int unsigned MAG_W  = SUM_W - 1;   // sum without the carry-out bit
    localparam int unsigned FRAC_W = 23;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned EXC_W  = 5;
    localparam int unsigned LZC_W  = 5;           // holds 0..26

    typedef struct packed {
        logic             sgn;
        logic             sa;
        logic             sb;
        logic             ctrl;
        logic             max_ab;
        logic [EXC_W-1:0] input_exc;
    } sideband_t;

endpackage

// File: rtl/fpaddsub_lzc26.sv
// Combinational 26-bit leading-zero counter; an all-zero input yields 26.
module fpaddsub_lzc26
    import fpaddsub_pkg::*;
(
    input  logic [MAG_W-1:0] value,
    output logic [LZC_W-1:0] count
);

    // Scan upward so the highest set bit has the final say.
    always_comb begin
        count = LZC_W'(MAG_W);
        for (int unsigned i = 0; i < MAG_W; i++) begin
            if (value[i]) begin
                count = LZC_W'(MAG_W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fpaddsub_normalize_stage.sv
// Two-stage normalization between the significand adder and the rounder:
// stage 1 captures the sum with its leading-zero count, stage 2 shifts and
// forms both candidate exponents. Valid/ready handshake on both sides.
module fpaddsub_normalize_stage
    import fpaddsub_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SUM_W-1:0]  SumIn,
    input  logic              StickyIn,
    input  logic [EXP_W-1:0]  ExpIn,
    input  logic              Sgn,
    input  logic              Sa,
    input  logic              Sb,
    input  logic              Ctrl,
    input  logic              MaxAB,
    input  logic [EXC_W-1:0]  InputExc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FRAC_W-1:0] NormM,
    output logic              R,
    output logic              S,
    output logic              MSBShift,
    output logic [EXP_W:0]    ExpOK,
    output logic [EXP_W:0]    ExpOF,
    output logic              ZeroSum,
    output logic              NegE,
    output logic              Sgn_q,
    output logic              Sa_q,
    output logic              Sb_q,
    output logic              Ctrl_q,
    output logic              MaxAB_q,
    output logic [EXC_W-1:0]  InputExc_q
);

    logic             adv1;
    logic             adv2;

    logic [LZC_W-1:0] lzc_raw;
    logic [LZC_W-1:0] k_in;

    logic             s1_valid;
    logic [MAG_W-1:0] s1_mant;
    logic             s1_msb;
    logic             s1_sticky;
    logic [EXP_W-1:0] s1_exp;
    logic [LZC_W-1:0] s1_k;
    sideband_t        s1_side;

    logic [MAG_W-2:0]  shifted;
    logic [FRAC_W-1:0] norm_m;
    logic              r_bit;
    logic              s_bit;
    logic              sum_zero;
    logic              zero_sum;
    logic              neg_e;
    logic [EXP_W:0]    exp_ext;
    logic [EXP_W:0]    k_ext;
    logic [EXP_W:0]    exp_ok;
    logic [EXP_W:0]    exp_of;

    sideband_t         out_side;

    assign adv2     = ~out_valid | out_ready;
    assign adv1     = ~s1_valid | adv2;
    assign in_ready = adv1;

    fpaddsub_lzc26 u_lzc (
        .value (SumIn[MAG_W-1:0]),
        .count (lzc_raw)
    );

    // A carry-out means a right shift by one, so the left-shift count is zero.
    assign k_in = SumIn[SUM_W-1] ? '0 : lzc_raw;

    // Stage 1: capture the sum, exponent, sideband, shift count and carry flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_mant   <= '0;
            s1_msb    <= 1'b0;
            s1_sticky <= 1'b0;
            s1_exp    <= '0;
            s1_k      <= '0;
            s1_side   <= '0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_mant   <= SumIn[MAG_W-1:0];
                s1_msb    <= SumIn[SUM_W-1];
                s1_sticky <= StickyIn;
                s1_exp    <= ExpIn;
                s1_k      <= k_in;
                s1_side   <= '{sgn: Sgn, sa: Sa, sb: Sb, ctrl: Ctrl,
                               max_ab: MaxAB, input_exc: InputExc};
            end
        end
    end

    // The top magnitude bit never survives into the fraction window after a
    // left shift, so only the lower 25 bits are shifted.
    assign shifted = s1_mant[MAG_W-2:0] << s1_k;

    // Stage 2 datapath: normalize fraction, exponent candidates and qualifiers.
    always_comb begin
        norm_m = '0;
        r_bit  = 1'b0;
        s_bit  = 1'b0;
        if (s1_msb) begin
            norm_m = s1_mant[MAG_W-1:3];
            r_bit  = s1_mant[2];
            s_bit  = s1_mant[1] | s1_mant[0] | s1_sticky;
        end else begin
            norm_m = shifted[MAG_W-2:2];
            r_bit  = shifted[1];
            s_bit  = shifted[0] | s1_sticky;
        end
        sum_zero = ~s1_msb & (s1_mant == '0);
        zero_sum = sum_zero & ~s1_sticky;
        exp_ext  = {1'b0, s1_exp};
        k_ext    = {{(EXP_W + 1 - LZC_W){1'b0}}, s1_k};
        exp_ok   = exp_ext - k_ext;
        exp_of   = exp_ext + 1'b1;
        // A sum that is only sticky has nothing left to normalize: underflow.
        neg_e    = ~zero_sum & ~s1_msb & ((exp_ext <= k_ext) | sum_zero);
    end

    // Stage 2: register the result; hold everything while the rounder stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            NormM     <= '0;
            R         <= 1'b0;
            S         <= 1'b0;
            MSBShift  <= 1'b0;
            ExpOK     <= '0;
            ExpOF     <= '0;
            ZeroSum   <= 1'b0;
            NegE      <= 1'b0;
            out_side  <= '0;
        end else if (adv2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                NormM    <= norm_m;
                R        <= r_bit;
                S        <= s_bit;
                MSBShift <= s1_msb;
                ExpOK    <= exp_ok;
                ExpOF    <= exp_of;
                ZeroSum  <= zero_sum;
                NegE     <= neg_e;
                out_side <= s1_side;
            end
        end
    end

    assign Sgn_q      = out_side.sgn;
    assign Sa_q       = out_side.sa;
    assign Sb_q       = out_side.sb;
    assign Ctrl_q     = out_side.ctrl;
    assign MaxAB_q    = out_side.max_ab;
    assign InputExc_q = out_side.input_exc;

endmodule

// File: tb/tb_fpaddsub_normalize_stage.sv
// Self-checking bench for fpaddsub_normalize_stage: directed vectors, a
// randomized stream against a reference model, stall and mid-stream reset.
module tb_fpaddsub_normalize_stage;

    typedef struct packed {
        logic [22:0] m;
        logic        rb;
        logic        sb;
        logic        msb;
        logic [8:0]  ok;
        logic [8:0]  of;
        logic        zero;
        logic        nege;
        logic [9:0]  side;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [26:0] SumIn = '0;
    logic        StickyIn = 1'b0;
    logic [7:0]  ExpIn = '0;
    logic        Sgn = 1'b0, Sa = 1'b0, Sb = 1'b0, Ctrl = 1'b0, MaxAB = 1'b0;
    logic [4:0]  InputExc = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [22:0] NormM;
    logic        R, S, MSBShift, ZeroSum, NegE;
    logic [8:0]  ExpOK, ExpOF;
    logic        o_sgn, o_sa, o_sb, o_ctrl, o_maxab;
    logic [4:0]  o_exc;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned n_timeouts = 0;
    logic        rand_ready = 1'b0;

    res_t exp_q[$];
    res_t obs_q[$];

    fpaddsub_normalize_stage dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .SumIn      (SumIn),
        .StickyIn   (StickyIn),
        .ExpIn      (ExpIn),
        .Sgn        (Sgn),
        .Sa         (Sa),
        .Sb         (Sb),
        .Ctrl       (Ctrl),
        .MaxAB      (MaxAB),
        .InputExc   (InputExc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .NormM      (NormM),
        .R          (R),
        .S          (S),
        .MSBShift   (MSBShift),
        .ExpOK      (ExpOK),
        .ExpOF      (ExpOF),
        .ZeroSum    (ZeroSum),
        .NegE       (NegE),
        .Sgn_q      (o_sgn),
        .Sa_q       (o_sa),
        .Sb_q       (o_sb),
        .Ctrl_q     (o_ctrl),
        .MaxAB_q    (o_maxab),
        .InputExc_q (o_exc)
    );

    always #5 clk = ~clk;

    // Behavioural reference: normalize by repeated doubling until the
    // leading one reaches the hidden-bit position.
    function automatic res_t model(input logic [26:0] sum, input logic st,
                                   input logic [7:0] e, input logic [9:0] sd);
        res_t        x;
        logic [25:0] v;
        int          k;
        x = '0;
        x.side = sd;
        k = 0;
        if (sum[26]) begin
            x.msb = 1'b1;
            x.m   = sum[25:3];
            x.rb  = sum[2];
            x.sb  = sum[1] | sum[0] | st;
        end else begin
            v = sum[25:0];
            while (k < 26 && !v[25]) begin
                v = v << 1;
                k++;
            end
            x.m  = v[24:2];
            x.rb = v[1];
            x.sb = v[0] | st;
        end
        x.ok   = 9'(int'(e) - k);
        x.of   = 9'(int'(e) + 1);
        x.zero = (sum == 27'd0) && !st;
        x.nege = !x.zero && !x.msb && ((int'(e) <= k) || (sum == 27'd0));
        return x;
    endfunction

    function automatic res_t cur();
        res_t x;
        x = '{m: NormM, rb: R, sb: S, msb: MSBShift, ok: ExpOK, of: ExpOF,
              zero: ZeroSum, nege: NegE,
              side: {o_sgn, o_sa, o_sb, o_ctrl, o_maxab, o_exc}};
        return x;
    endfunction

    // Record every result the rounder would actually take.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) obs_q.push_back(cur());
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [26:0] sum, input logic st,
                        input logic [7:0] e, input logic [9:0] sd);
        int unsigned waitc = 0;
        logic        acc;
        in_valid = 1'b1;
        SumIn    = sum;
        StickyIn = st;
        ExpIn    = e;
        {Sgn, Sa, Sb, Ctrl, MaxAB, InputExc} = sd;
        forever begin
            @(negedge clk);
            acc = in_ready;
            tick();
            if (acc) break;
            waitc++;
            if (waitc > 100) begin
                n_timeouts++;
                break;
            end
        end
        if (acc) exp_q.push_back(model(sum, st, e, sd));
    endtask

    task automatic drain();
        int unsigned c = 0;
        in_valid = 1'b0;
        while (obs_q.size() < exp_q.size() && c < 500) begin
            tick();
            c++;
        end
        repeat (4) tick();
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        n_checks++;
        if (cur() !== res_t'(0)) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected 0", cur());
        end
        tick();
    endtask

    task automatic test_directed();
        logic [26:0] sums [6] = '{27'h6000000, 27'h2000007, 27'h0000008,
                                  27'h0000008, 27'h0000000, 27'h0000000};
        logic        sts  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [7:0]  exps [6] = '{8'd127, 8'd100, 8'd30, 8'd22, 8'd90, 8'd90};
        res_t        want [6];
        want[0] = '{m: 23'h400000, rb: 0, sb: 0, msb: 1, ok: 9'd127, of: 9'd128, zero: 0, nege: 0, side: 10'h000};
        want[1] = '{m: 23'h000001, rb: 1, sb: 1, msb: 0, ok: 9'd100, of: 9'd101, zero: 0, nege: 0, side: 10'h000};
        want[2] = '{m: 23'h000000, rb: 0, sb: 0, msb: 0, ok: 9'd8,   of: 9'd31,  zero: 0, nege: 0, side: 10'h000};
        want[3] = '{m: 23'h000000, rb: 0, sb: 0, msb: 0, ok: 9'd0,   of: 9'd23,  zero: 0, nege: 1, side: 10'h000};
        want[4] = '{m: 23'h000000, rb: 0, sb: 0, msb: 0, ok: 9'd64,  of: 9'd91,  zero: 1, nege: 0, side: 10'h000};
        want[5] = '{m: 23'h000000, rb: 0, sb: 1, msb: 0, ok: 9'd64,  of: 9'd91,  zero: 0, nege: 1, side: 10'h000};
        out_ready  = 1'b1;
        rand_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(sums[i], sts[i], exps[i], 10'h000);
        drain();
        n_checks++;
        if (obs_q.size() != 6) begin
            n_fail++; $display("FAIL directed_count: got %0d expected 6", obs_q.size());
        end
        for (int i = 0; i < 6 && obs_q.size() > 0; i++) begin
            res_t got;
            got = obs_q.pop_front();
            n_checks++;
            if (got !== want[i]) begin
                n_fail++; $display("FAIL directed_%0d: got %h expected %h", i, got, want[i]);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_random();
        int unsigned n_items = 300;
        rand_ready = 1'b1;
        for (int unsigned i = 0; i < n_items; i++) begin
            logic [26:0] sum;
            logic [7:0]  e;
            case ($urandom_range(0, 5))
                0:       sum = {1'b1, 26'($urandom)};
                1:       sum = {2'b01, 25'($urandom)};
                2, 3:    sum = {1'b0, 26'($urandom) >> $urandom_range(0, 26)};
                4:       sum = '0;
                default: sum = 27'($urandom);
            endcase
            e = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'($urandom_range(0, 30));
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                tick();
            end
            send(sum, 1'($urandom_range(0, 1)), e, 10'($urandom));
        end
        drain();
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        n_checks++;
        if (obs_q.size() != exp_q.size() || n_timeouts != 0) begin
            n_fail++;
            $display("FAIL random_count: got %0d results (%0d timeouts) expected %0d",
                     obs_q.size(), n_timeouts, exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            res_t got, want;
            got  = obs_q.pop_front();
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++; $display("FAIL random_item: got %h expected %h", got, want);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_back_to_back();
        int   idx = 0;
        logic saw_stall = 1'b0;
        logic have_prev = 1'b0;
        res_t prev = '0;
        rand_ready = 1'b0;
        for (int t = 0; t < 20; t++) begin
            logic [26:0] sum;
            logic [7:0]  e;
            logic [9:0]  sd;
            sum = 27'h0400000 >> idx | 27'(idx);
            e   = 8'(50 + idx * 10);
            sd  = 10'(idx * 37 + 5);
            out_ready = !(t >= 3 && t <= 6);
            if (idx < 5) begin
                in_valid = 1'b1;
                SumIn    = sum;
                StickyIn = idx[0];
                ExpIn    = e;
                {Sgn, Sa, Sb, Ctrl, MaxAB, InputExc} = sd;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (!in_ready) saw_stall = 1'b1;
            if (have_prev) begin
                n_checks++;
                if (cur() !== prev || out_valid !== 1'b1) begin
                    n_fail++; $display("FAIL stall_hold: got %h expected %h", cur(), prev);
                end
            end
            have_prev = out_valid && !out_ready;
            prev = cur();
            if (in_valid && in_ready) begin
                exp_q.push_back(model(sum, idx[0], e, sd));
                idx++;
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        drain();
        n_checks++;
        if (saw_stall !== 1'b1) begin
            n_fail++; $display("FAIL b2b_in_ready_drop: got %b expected 1", saw_stall);
        end
        n_checks++;
        if (obs_q.size() != 5 || exp_q.size() != 5) begin
            n_fail++; $display("FAIL b2b_count: got %0d expected 5", obs_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            res_t got, want;
            got  = obs_q.pop_front();
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++; $display("FAIL b2b_item: got %h expected %h", got, want);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_mid_reset();
        rand_ready = 1'b0;
        out_ready  = 1'b0;
        send(27'h3FFFFFF, 1'b0, 8'd10, 10'h3FF);
        send(27'h1234567, 1'b1, 8'd200, 10'h155);
        in_valid = 1'b0;
        exp_q.delete();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready);
        end
        n_checks++;
        if (cur() !== res_t'(0)) begin
            n_fail++; $display("FAIL midrst_outputs: got %h expected 0", cur());
        end
        out_ready = 1'b1;
        repeat (6) tick();
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++; $display("FAIL midrst_discard: got %0d results expected 0", obs_q.size());
        end
        obs_q.delete();
        send(27'h0000100, 1'b0, 8'd40, 10'h2A5);
        drain();
        n_checks++;
        if (obs_q.size() != 1 || exp_q.size() != 1) begin
            n_fail++; $display("FAIL midrst_after_count: got %0d expected 1", obs_q.size());
        end else begin
            res_t got, want;
            got  = obs_q.pop_front();
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++; $display("FAIL midrst_after_item: got %h expected %h", got, want);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
